seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/seg_scan_ctrl_hex_to_seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the eight-digit seven-segment scan controller:
// digit count, the active-low hex segment table and the scan FSM states.
package seg_scan_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-low {g,f,e,d,c,b,a}. Entry n is the glyph for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit seven-segment scanner with double-buffered display data.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of digits 7..1.
//
// state | meaning
// BLANK | start of a digit slot, all digits off to suppress ghosting
// SHOW  | current digit enabled with its decoded segments
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV      = 12500,
   parameter int BLANK_CYCLES = 1250
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  LEDSEL,
   output logic [7:0]  LEDOUT,
   output logic        frame_done
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   scan_state_e      state_q, state_d;
   logic [31:0]      shadow_val_q, shadow_val_d;
   logic [7:0]       shadow_dp_q, shadow_dp_d;
   logic             pending_q, pending_d;
   logic [31:0]      disp_val_q, disp_val_d;
   logic [7:0]       disp_dp_q, disp_dp_d;
   logic [7:0]       ledsel_q, ledsel_d;
   logic [7:0]       ledout_q, ledout_d;
   logic             frame_done_q, frame_done_d;

   logic       slot_wrap;
   logic       frame_wrap;
   logic [3:0] cur_nib;
   logic [6:0] cur_seg;
   logic       digit_blank;

   assign slot_wrap  = (cnt_q == CNT_LAST);
   assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
   assign cur_nib    = disp_val_q[{idx_q, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .nibble (cur_nib),
      .seg_n  (cur_seg)
   );

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lz_blank;

   // A digit is blank when it and every digit above it is zero and its dp is off.
   always_comb begin : lzb_calc
      logic upper_zero;
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero  = upper_zero & (disp_val_q[4*i +: 4] == 4'h0);
         lz_blank[i] = upper_zero & ~disp_dp_q[i];
      end
   end

   assign digit_blank = lz_blank[idx_q];
`else
   assign digit_blank = 1'b0;
`endif

   always_comb begin
      cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // state tracks the phase of the cnt value it is registered alongside
      state_d = (cnt_d < CNT_BLANK) ? BLANK : SHOW;

      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_mask;
      end

      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      pending_d  = pending_q | load;
      if (frame_wrap) begin
         pending_d = 1'b0;
         if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_mask;
         end else if (pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
      end

      ledsel_d = 8'hFF;
      ledout_d = 8'hFF;
      if (state_q == SHOW && !digit_blank) begin
         ledsel_d = ~(8'h01 << idx_q);
         ledout_d = {~disp_dp_q[idx_q], cur_seg};
      end

      frame_done_d = frame_wrap;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         state_q      <= BLANK;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         ledsel_q     <= 8'hFF;
         ledout_q     <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         ledsel_q     <= ledsel_d;
         ledout_q     <= ledout_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign LEDSEL     = ledsel_q;
   assign LEDOUT     = ledout_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level model predicts each lit digit,
// a negedge monitor pops and compares as the DUT lights digits.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV      = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = 8 * CLK_DIV;
   localparam int SHOW_LEN     = CLK_DIV - BLANK_CYCLES;
   localparam int PERIOD       = 10;

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [31:0] value = '0;
   logic [7:0]  dp_mask = '0;
   logic [7:0]  LEDSEL;
   logic [7:0]  LEDOUT;
   logic        frame_done;

   seg_scan_ctrl #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .Clk        (Clk),
      .reset      (reset),
      .load       (load),
      .value      (value),
      .dp_mask    (dp_mask),
      .LEDSEL     (LEDSEL),
      .LEDOUT     (LEDOUT),
      .frame_done (frame_done)
   );

   always #(PERIOD/2) Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] sel;
      logic [7:0] seg;
      time        at;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   function automatic bit digit_lit(input logic [31:0] w, input logic [7:0] dp, input int d);
`ifdef SEG_SCAN_LZB_EN
      return (d == 0) || ((w >> (4 * d)) != 32'h0) || (dp[d] == 1'b1);
`else
      return 1'b1;
`endif
   endfunction

   // Reference model: edges counted from reset release, display word per frame.
   int          m_edge = 0;
   logic [31:0] m_disp = '0, m_shadow = '0;
   logic [7:0]  m_dp = '0, m_sdp = '0;
   bit          m_pend = 1'b0;
   bit          exp_fd = 1'b0;

   always @(posedge Clk) begin : model
      bit   boundary;
      int   d;
      exp_t e;
      if (reset) begin
         m_edge   = 0;
         m_disp   = '0;
         m_shadow = '0;
         m_dp     = '0;
         m_sdp    = '0;
         m_pend   = 1'b0;
         exp_fd   = 1'b0;
         sb.delete();
      end else begin
         boundary = ((m_edge % FRAME) == FRAME - 1);
         if (load) begin
            if (boundary) begin
               m_disp = value;
               m_dp   = dp_mask;
               m_pend = 1'b0;
            end else begin
               m_shadow = value;
               m_sdp    = dp_mask;
               m_pend   = 1'b1;
            end
         end else if (boundary && m_pend) begin
            m_disp = m_shadow;
            m_dp   = m_sdp;
            m_pend = 1'b0;
         end
         exp_fd = boundary;
         if ((m_edge % CLK_DIV) == 0) begin
            d = (m_edge / CLK_DIV) % 8;
            if (digit_lit(m_disp, m_dp, d)) begin
               e.sel = ~(8'h01 << d);
               e.seg = hex_seg(m_disp[4*d +: 4]);
               if (m_dp[d]) e.seg[7] = 1'b0;
               e.at  = $time + BLANK_CYCLES * PERIOD + PERIOD / 2;
               sb.push_back(e);
            end
         end
         m_edge++;
      end
   end

   bit         in_run = 1'b0;
   int         run_len = 0;
   logic [7:0] run_sel = '0;
   logic [7:0] run_seg = '0;
   bit         fd_seen = 1'b0;
   time        last_fd = 0;
   int         fd_count = 0;

   always @(negedge Clk) begin : monitor
      exp_t e;
      if (reset) begin
         in_run   = 1'b0;
         run_len  = 0;
         fd_seen  = 1'b0;
         fd_count = 0;
      end else begin
         if (LEDSEL != 8'hFF) begin
            if (!in_run || LEDSEL != run_sel) begin
               if (in_run) check("show_len", run_len, SHOW_LEN);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_digit: LEDSEL %h LEDOUT %h with no digit expected at %0t",
                           LEDSEL, LEDOUT, $time);
                  run_seg = LEDOUT;
               end else begin
                  e = sb.pop_front();
                  check("digit_sel", LEDSEL, e.sel);
                  check("digit_seg", LEDOUT, e.seg);
                  check("digit_time", $time, e.at);
                  run_seg = e.seg;
               end
               in_run  = 1'b1;
               run_len = 1;
               run_sel = LEDSEL;
            end else begin
               run_len++;
               check("seg_hold", LEDOUT, run_seg);
            end
         end else begin
            if (in_run) check("show_len", run_len, SHOW_LEN);
            in_run = 1'b0;
            check("blank_seg", LEDOUT, 8'hFF);
         end
         check("frame_done", frame_done, exp_fd);
         if (frame_done) begin
            if (fd_seen) check("fd_spacing", $time - last_fd, FRAME * PERIOD);
            fd_seen = 1'b1;
            last_fd = $time;
            fd_count++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #2;
      end
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dp);
      load    = 1'b1;
      value   = v;
      dp_mask = dp;
      tick(1);
      load    = 1'b0;
   endtask

   // Return when the next rising edge is at frame phase ph.
   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while ((m_edge % FRAME) != ph && n < 2 * FRAME) begin
         tick(1);
         n++;
      end
      if ((m_edge % FRAME) != ph) begin
         checks++;
         errors++;
         $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, m_edge % FRAME);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_ledsel", LEDSEL, 8'hFF);
      check("rst_ledout", LEDOUT, 8'hFF);
      check("rst_frame_done", frame_done, 1'b0);
   endtask

   initial begin
      logic [31:0] v;
      reset = 1'b1;
      tick(3);
      check_reset_outputs();
      reset = 1'b0;

      tick(FRAME + 20);
      do_load(32'h12345678, 8'h08);
      tick(2 * FRAME);

      wait_phase(FRAME - 1);
      do_load(32'hFFFFFFFF, 8'h00);
      tick(FRAME + 5);

      wait_phase(10);
      do_load(32'hDEADBEEF, 8'hA5);
      tick(12);
      do_load(32'h0BADF00D, 8'h3C);
      tick(2 * FRAME);

      wait_phase(30);
      do_load(32'h00000A00, 8'h00);
      tick(2 * FRAME);
      do_load(32'h00000000, 8'h00);
      tick(2 * FRAME);
      do_load(32'h00000000, 8'h40);
      tick(2 * FRAME);

      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 7));
         if ($urandom_range(0, 3) == 0) wait_phase(FRAME - 1);
         do_load(v, 8'($urandom_range(0, 255)));
         tick($urandom_range(1, 2 * FRAME));
      end
      tick(2 * FRAME);

      wait_phase(5 * CLK_DIV + 4);
      reset = 1'b1;
      #1;
      check_reset_outputs();
      tick(3);
      check_reset_outputs();
      reset = 1'b0;
      tick(3 * FRAME + 10);
      check("fd_count_3_frames", fd_count, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
